// File: rtl/pixel_sub_pkg.sv
// pixel_sub_pkg: shared defaults, pixel type and transform modes for the pixel sub-stages
//   DEF_COMP_W / DEF_NUM_COMP / DEF_PIX_W : default component width, count and pixel width
//   pixel_t                               : default-width pixel, component 0 in LSBs
//   mode_t                                : per-pixel transform select
package pixel_sub_pkg;
   localparam int DEF_COMP_W = 8;
   localparam int DEF_NUM_COMP = 3;
   localparam int DEF_PIX_W = DEF_COMP_W * DEF_NUM_COMP;
   typedef logic [DEF_PIX_W-1:0] pixel_t;
   typedef enum logic [1:0] {MODE_PASS, MODE_REV, MODE_INV, MODE_MONO} mode_t;
endpackage

// File: rtl/pixel_sync_fifo.sv
// pixel_sync_fifo: DEPTH-entry synchronous FIFO with show-ahead head output
//   cp    : clock, rising edge
//   reset : asynchronous active-low reset, empties the FIFO
//   push  : write din (caller must not push when full)
//   pop   : drop the head entry (caller must not pop when empty)
//   din   : entry to write
//   dout  : head entry, valid while !empty
//   full  : DEPTH entries held
//   empty : no entries held
module pixel_sync_fifo #(
   parameter int W = 25,
   parameter int DEPTH = 4
) (
   input  logic         cp,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0] cnt;
   assign dout = mem[rp];
   assign full = cnt == (AW+1)'(DEPTH);
   assign empty = cnt == '0;
   always_ff @(posedge cp)
      if (push) mem[wp] <= din;
   // DEPTH is a power of two, so the pointers wrap by plain overflow
   always_ff @(posedge cp or negedge reset)
      if (!reset) begin
         wp <= '0;
         rp <= '0;
         cnt <= '0;
      end else begin
         wp <= wp + AW'(push);
         rp <= rp + AW'(pop);
         cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      end
endmodule

// File: rtl/pixel_stage_sub1_p.sv
// pixel_stage_sub1_p: transforms accepted pixels, buffers them and tags line position on output
//   cp / reset            : clock (rising edge) and asynchronous active-low reset
//   sub1_in_valid/ready   : input handshake; ready = !full, low while in reset
//   sub1_in_pixel/sof     : input pixel (component 0 in LSBs) and start-of-frame tag
//   sub1_mode             : transform applied to the pixel accepted this cycle
//   sub1_out_valid/ready  : output handshake for the FIFO head
//   sub1_out_pixel        : transformed head pixel, zero when nothing is buffered
//   sub1_to_sub2          : head pixel is the last of its line
//   sub1_to_sub2_and_top  : registered count of lines completed since the last sof
module pixel_stage_sub1_p
   import pixel_sub_pkg::*;
#(
   parameter int COMP_W = DEF_COMP_W,
   parameter int NUM_COMP = DEF_NUM_COMP,
   parameter int DEPTH = 4,
   parameter int LINE_LEN = 640,
   parameter int LCNT_W = 12
) (
   input  logic                       cp,
   input  logic                       reset,
   input  logic                       sub1_in_valid,
   output logic                       sub1_in_ready,
   input  logic [COMP_W*NUM_COMP-1:0] sub1_in_pixel,
   input  logic                       sub1_in_sof,
   input  logic [1:0]                 sub1_mode,
   output logic                       sub1_out_valid,
   input  logic                       sub1_out_ready,
   output logic [COMP_W*NUM_COMP-1:0] sub1_out_pixel,
   output logic                       sub1_to_sub2,
   output logic [LCNT_W-1:0]          sub1_to_sub2_and_top
);
   localparam int PIX_W = COMP_W * NUM_COMP;
   localparam int CW = $clog2(LINE_LEN);
   localparam logic [CW-1:0] LAST = CW'(LINE_LEN - 1);
   mode_t mode;
   logic [PIX_W-1:0] xf, head_pix;
   logic head_sof, push, pop, full, empty, eol;
   logic [CW-1:0] col, eff_col;
   logic [LCNT_W-1:0] lcnt;
   assign mode = mode_t'(sub1_mode);
   always_comb begin
      xf = '0;
      for (int i = 0; i < NUM_COMP; i++)
         xf[i*COMP_W +: COMP_W] =
            mode == MODE_REV  ? sub1_in_pixel[(NUM_COMP-1-i)*COMP_W +: COMP_W] :
            mode == MODE_INV  ? ~sub1_in_pixel[i*COMP_W +: COMP_W] :
            mode == MODE_MONO ? sub1_in_pixel[COMP_W-1:0] :
                                sub1_in_pixel[i*COMP_W +: COMP_W];
   end
   // reset gates ready so nothing is accepted while the stage is held in reset
   assign sub1_in_ready = reset && !full;
   assign push = sub1_in_valid && sub1_in_ready;
   assign sub1_out_valid = !empty;
   assign pop = sub1_out_valid && sub1_out_ready;
   pixel_sync_fifo #(.W(PIX_W + 1), .DEPTH(DEPTH)) u_fifo (
      .cp(cp),
      .reset(reset),
      .push(push),
      .pop(pop),
      .din({sub1_in_sof, xf}),
      .dout({head_sof, head_pix}),
      .full(full),
      .empty(empty)
   );
   // an sof head starts a new line regardless of where the previous one got to
   assign eff_col = head_sof ? '0 : col;
   assign eol = sub1_out_valid && eff_col == LAST;
   assign sub1_to_sub2 = eol;
   assign sub1_out_pixel = sub1_out_valid ? head_pix : '0;
   assign sub1_to_sub2_and_top = lcnt;
   always_ff @(posedge cp or negedge reset)
      if (!reset) begin
         col <= '0;
         lcnt <= '0;
      end else if (pop) begin
         col <= eol ? '0 : eff_col + CW'(1);
         lcnt <= head_sof ? '0 : eol ? lcnt + LCNT_W'(1) : lcnt;
      end
endmodule
